// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: shares the single register-file write port between the
// in-order WB stage and the mul/div unit. MDU results queue in a small FIFO,
// a pending-destination scoreboard drives the decode RAW stall, and a starve
// counter freezes WB when a queued MDU result has waited too long.
module rf_wr_arbiter #(
    parameter int DW         = 32,
    parameter int AW         = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic          wb_stall,
    input  logic          md_valid,
    output logic          md_ready,
    input  logic [AW-1:0] md_addr,
    input  logic [DW-1:0] md_data,
    input  logic          md_issue,
    input  logic [AW-1:0] md_issue_rd,
    input  logic [AW-1:0] dec_rs,
    input  logic [AW-1:0] dec_rt,
    output logic          dec_stall,
    output logic          RFWr,
    output logic [AW-1:0] A3,
    output logic [DW-1:0] WD
);

    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW   = PW + 1;
    localparam int SW   = $clog2(STARVE_LIM + 1);
    localparam int NREG = 1 << AW;
    localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_LIM - 1);

    logic [AW-1:0]   fifo_addr [FIFO_DEPTH];
    logic [DW-1:0]   fifo_data [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic [SW-1:0]   starve_cnt;
    logic [NREG-1:0] pending;
    logic            fifo_empty;
    logic            wb_win;
    logic            push;
    logic            pop;
    logic            starve_inc;
    logic [AW-1:0]   head_addr;
    logic [DW-1:0]   head_data;

    // Grant decision: WB first unless frozen, otherwise drain the FIFO head.
    always_comb begin
        fifo_empty = (count == '0);
        md_ready   = (count != FULL_CNT);
        push       = md_valid && md_ready;
        wb_win     = !wb_stall && wb_en && (wb_addr != '0);
        pop        = !wb_win && !fifo_empty;
        starve_inc = !fifo_empty && !pop;
        head_addr  = fifo_addr[rd_ptr];
        head_data  = fifo_data[rd_ptr];
        count_nxt  = count;
        if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (!push && pop) begin
            count_nxt = count - 1'b1;
        end
    end

    assign dec_stall = ((dec_rs != '0) && pending[dec_rs]) ||
                       ((dec_rt != '0) && pending[dec_rt]);

    // FIFO storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= md_addr;
            fifo_data[wr_ptr] <= md_data;
        end
    end

    // FIFO pointers, occupancy, starve counter and the WB freeze.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            wb_stall   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            if (starve_inc) begin
                starve_cnt <= starve_cnt + 1'b1;
            end else begin
                starve_cnt <= '0;
            end
            // Release the freeze as soon as the backlog is gone.
            if (count_nxt == '0) begin
                wb_stall <= 1'b0;
            end else if (starve_inc && (starve_cnt == STARVE_TOP)) begin
                wb_stall <= 1'b1;
            end
        end
    end

    // RF write port registers; an MDU result for r0 is drained without a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RFWr <= 1'b0;
            A3   <= '0;
            WD   <= '0;
        end else if (wb_win) begin
            RFWr <= 1'b1;
            A3   <= wb_addr;
            WD   <= wb_data;
        end else if (pop) begin
            RFWr <= (head_addr != '0);
            A3   <= head_addr;
            WD   <= head_data;
        end else begin
            RFWr <= 1'b0;
        end
    end

    // Pending-destination scoreboard; a new issue beats a same-edge retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            if (pop && (head_addr != '0)) begin
                pending[head_addr] <= 1'b0;
            end
            if (md_issue && (md_issue_rd != '0)) begin
                pending[md_issue_rd] <= 1'b1;
            end
        end
    end

endmodule
